// File: rtl/ball_pkg.sv
// Shared constants for the colour-detect box controller: config addresses,
// reset thresholds and FSM state encoding.
package ball_pkg;

    localparam logic [1:0] CFG_CB_LO = 2'd0;
    localparam logic [1:0] CFG_CB_HI = 2'd1;
    localparam logic [1:0] CFG_CR_LO = 2'd2;
    localparam logic [1:0] CFG_CR_HI = 2'd3;

    localparam logic [7:0] DEF_CB_LO = 8'h30;
    localparam logic [7:0] DEF_CB_HI = 8'h80;
    localparam logic [7:0] DEF_CR_LO = 8'hC8;
    localparam logic [7:0] DEF_CR_HI = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_PUBLISH
    } state_t;

    function automatic logic [7:0] def_thresh(input logic [1:0] addr);
        case (addr)
            CFG_CB_LO: return DEF_CB_LO;
            CFG_CB_HI: return DEF_CB_HI;
            CFG_CR_LO: return DEF_CR_LO;
            default:   return DEF_CR_HI;
        endcase
    endfunction

endpackage

// File: rtl/ball_thresh_regs.sv
// Cb/Cr threshold window: software writes land in shadow registers, and the
// active set used for matching only changes on the commit strobe.
module ball_thresh_regs
    import ball_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       commit,
    output logic [7:0] cb_lo,
    output logic [7:0] cb_hi,
    output logic [7:0] cr_lo,
    output logic [7:0] cr_hi
);

    logic [7:0] shadow [4];
    logic [7:0] active [4];

    // A write on the commit cycle lands in the shadow after the copy, so it waits a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= def_thresh(2'(i));
                active[i] <= def_thresh(2'(i));
            end
        end else begin
            if (cfg_wr) begin
                shadow[cfg_addr] <= cfg_wdata;
            end
            if (commit) begin
                for (int i = 0; i < 4; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    assign cb_lo = active[CFG_CB_LO];
    assign cb_hi = active[CFG_CB_HI];
    assign cr_lo = active[CFG_CR_LO];
    assign cr_hi = active[CFG_CR_HI];

endmodule

// File: rtl/ball_box_ctrl.sv
// Colour-detect frame controller: pixel mask, per-frame bounding box, frame-synced thresholds.
// Define BOX_CENTER_EN to add the registered box_cx/box_cy centre outputs.
module ball_box_ctrl
    import ball_pkg::*;
#(
    parameter  int H_RES   = 640,
    parameter  int V_RES   = 480,
    parameter  int MIN_PIX = 64,
    localparam int X_W     = $clog2(H_RES),
    localparam int Y_W     = $clog2(V_RES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vsync,
    input  logic           in_hsync,
    input  logic           in_de,
    input  logic [7:0]     in_cb,
    input  logic [7:0]     in_cr,
    input  logic           cfg_wr,
    input  logic [1:0]     cfg_addr,
    input  logic [7:0]     cfg_wdata,
    output logic           mask_vsync,
    output logic           mask_hsync,
    output logic           mask_de,
    output logic [7:0]     mask_data,
    output logic           box_valid,
    output logic           box_found,
    output logic [X_W-1:0] box_x0,
    output logic [X_W-1:0] box_x1,
    output logic [Y_W-1:0] box_y0,
    output logic [Y_W-1:0] box_y1
`ifdef BOX_CENTER_EN
    ,
    output logic [X_W-1:0] box_cx,
    output logic [Y_W-1:0] box_cy
`endif
);

    localparam logic [X_W-1:0] X_MAX   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(V_RES - 1);
    localparam logic [19:0]    CNT_MAX = 20'hFFFFF;
    localparam logic [19:0]    CNT_MIN = 20'(MIN_PIX);

    state_t state, state_next;

    logic           vsync_rise, de_fall, match, any_hit;
    logic           clear_trk, load_box;
    logic [7:0]     cb_lo, cb_hi, cr_lo, cr_hi;
    logic [X_W-1:0] x, x_min, x_max;
    logic [Y_W-1:0] y, y_min, y_max;
    logic [19:0]    pix_cnt;

    // The delayed syncs double as the edge-detect history.
    assign vsync_rise = in_vsync & ~mask_vsync;
    assign de_fall    = mask_de & ~in_de;
    assign match      = in_de && (in_cb > cb_lo) && (in_cb < cb_hi)
                              && (in_cr > cr_lo) && (in_cr < cr_hi);
    assign any_hit    = (pix_cnt != 20'd0);

    ball_thresh_regs u_thresh (
        .clk       (clk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .commit    (vsync_rise),
        .cb_lo     (cb_lo),
        .cb_hi     (cb_hi),
        .cr_lo     (cr_lo),
        .cr_hi     (cr_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_vsync <= 1'b0;
            mask_hsync <= 1'b0;
            mask_de    <= 1'b0;
            mask_data  <= 8'h00;
        end else begin
            mask_vsync <= in_vsync;
            mask_hsync <= in_hsync;
            mask_de    <= in_de;
            mask_data  <= match ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Box registers load on the closing vsync edge, so they are already valid while box_valid is high.
    always_comb begin
        state_next = state;
        clear_trk  = 1'b0;
        load_box   = 1'b0;
        box_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vsync_rise) begin
                    state_next = ST_ACTIVE;
                    clear_trk  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) begin
                    state_next = ST_PUBLISH;
                    load_box   = 1'b1;
                end
            end
            ST_PUBLISH: begin
                state_next = ST_ACTIVE;
                clear_trk  = 1'b1;
                box_valid  = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear_trk) begin
            x <= '0;
            y <= '0;
        end else if (de_fall) begin
            x <= '0;
            if (y != Y_MAX) y <= y + 1'b1;
        end else if (in_de && x != X_MAX) begin
            x <= x + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_trk) begin
            x_min   <= '1;
            x_max   <= '0;
            y_min   <= '1;
            y_max   <= '0;
            pix_cnt <= '0;
        end else if (match && state == ST_ACTIVE) begin
            if (x < x_min) x_min <= x;
            if (x > x_max) x_max <= x;
            if (y < y_min) y_min <= y;
            if (y > y_max) y_max <= y;
            if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
        end
    end

`ifdef BOX_CENTER_EN
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    assign x_sum = {1'b0, x_min} + {1'b0, x_max};
    assign y_sum = {1'b0, y_min} + {1'b0, y_max};
`endif

    // An empty frame reports zero coordinates rather than the all-ones min seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            box_found <= 1'b0;
            box_x0    <= '0;
            box_x1    <= '0;
            box_y0    <= '0;
            box_y1    <= '0;
`ifdef BOX_CENTER_EN
            box_cx    <= '0;
            box_cy    <= '0;
`endif
        end else if (load_box) begin
            box_found <= (pix_cnt >= CNT_MIN);
            box_x0    <= any_hit ? x_min : '0;
            box_x1    <= any_hit ? x_max : '0;
            box_y0    <= any_hit ? y_min : '0;
            box_y1    <= any_hit ? y_max : '0;
`ifdef BOX_CENTER_EN
            box_cx    <= any_hit ? x_sum[X_W:1] : '0;
            box_cy    <= any_hit ? y_sum[Y_W:1] : '0;
`endif
        end
    end

endmodule

// File: tb/tb_ball_box_ctrl.sv
// Self-checking bench for ball_box_ctrl: pixel classification vectors plus
// frame-level sequences for box publish, thresholds, reset and clamping.
module tb_ball_box_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vsync, in_hsync, in_de;
    logic [7:0] in_cb, in_cr;
    logic       cfg_wr;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       mask_vsync, mask_hsync, mask_de;
    logic [7:0] mask_data;
    logic       box_valid, box_found;
    logic [9:0] box_x0, box_x1;
    logic [8:0] box_y0, box_y1;
`ifdef BOX_CENTER_EN
    logic [9:0] box_cx;
    logic [8:0] box_cy;
`endif

    int tests  = 0;
    int errors = 0;
    int pulses;

    typedef struct {
        logic       de;
        logic       hsync;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t vecs [8];

    ball_box_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_vsync   (in_vsync),
        .in_hsync   (in_hsync),
        .in_de      (in_de),
        .in_cb      (in_cb),
        .in_cr      (in_cr),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .mask_vsync (mask_vsync),
        .mask_hsync (mask_hsync),
        .mask_de    (mask_de),
        .mask_data  (mask_data),
        .box_valid  (box_valid),
        .box_found  (box_found),
        .box_x0     (box_x0),
        .box_x1     (box_x1),
        .box_y0     (box_y0),
        .box_y1     (box_y1)
`ifdef BOX_CENTER_EN
        ,
        .box_cx     (box_cx),
        .box_cy     (box_cy)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_de    = v.de;
        in_hsync = v.hsync;
        in_cb    = v.cb;
        in_cr    = v.cr;
        tick();
    endtask

    task automatic checkPixel(input string name, input logic [7:0] cb, input logic [8:0] exp);
        in_de = 1'b1;
        in_cb = cb;
        in_cr = 8'hE0;
        tick();
        checkOutput(name, 32'(mask_data), 32'(exp));
        in_de = 1'b0;
        tick();
    endtask

    // Matching pixels use cb=0x50 cr=0xE0; all others cb=0x10.
    task automatic sendFrame(input int lines, input int pix, input int xl, input int xh,
                             input int yl, input int yh);
        for (int yy = 0; yy < lines; yy++) begin
            for (int xx = 0; xx < pix; xx++) begin
                in_de = 1'b1;
                in_cb = (xx >= xl && xx <= xh && yy >= yl && yy <= yh) ? 8'h50 : 8'h10;
                in_cr = 8'hE0;
                tick();
            end
            in_de    = 1'b0;
            in_hsync = 1'b1;
            tick();
            in_hsync = 1'b0;
            tick();
        end
    endtask

    task automatic vsyncPulse(input logic wr, input logic [7:0] wd, output int npulse);
        npulse    = 0;
        in_vsync  = 1'b1;
        cfg_wr    = wr;
        cfg_addr  = 2'd0;
        cfg_wdata = wd;
        for (int i = 0; i < 6; i++) begin
            tick();
            cfg_wr = 1'b0;
            if (i == 1) in_vsync = 1'b0;
            if (box_valid) npulse++;
        end
    endtask

    task automatic checkBox(input string name, input int f, input int x0, input int x1,
                            input int y0, input int y1);
        checkOutput({name, " found"}, 32'(box_found), 32'(f));
        checkOutput({name, " x0"}, 32'(box_x0), 32'(x0));
        checkOutput({name, " x1"}, 32'(box_x1), 32'(x1));
        checkOutput({name, " y0"}, 32'(box_y0), 32'(y0));
        checkOutput({name, " y1"}, 32'(box_y1), 32'(y1));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h50, 8'hE0, 8'hFF};
        vecs[1] = '{1'b1, 1'b1, 8'h80, 8'hE0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h30, 8'hE0, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 8'h31, 8'hC9, 8'hFF};
        vecs[4] = '{1'b1, 1'b1, 8'h7F, 8'hFE, 8'hFF};
        vecs[5] = '{1'b1, 1'b0, 8'h50, 8'hC8, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'h50, 8'hFF, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 8'h50, 8'hE0, 8'h00};

        rst = 1'b1; in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0;
        in_cb = 8'h00; in_cr = 8'h00; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        checkOutput("reset mask_data", 32'(mask_data), 32'h0);
        checkOutput("reset box_valid", 32'(box_valid), 32'h0);
        checkBox("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d mask_data", i), 32'(mask_data), 32'(vecs[i].exp_mask));
            checkOutput($sformatf("vec%0d mask_de", i), 32'(mask_de), 32'(vecs[i].de));
            checkOutput($sformatf("vec%0d mask_hsync", i), 32'(mask_hsync), 32'(vecs[i].hsync));
        end
        in_de = 1'b0; in_hsync = 1'b0;
        tick();

        vsyncPulse(1'b0, 8'h00, pulses);
        checkOutput("first vsync no publish", 32'(pulses), 32'd0);

        sendFrame(62, 128, 100, 120, 50, 60);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkOutput("box frame pulses", 32'(pulses), 32'd1);
        checkBox("box frame", 1, 100, 120, 50, 60);
`ifdef BOX_CENTER_EN
        checkOutput("box frame cx", 32'(box_cx), 32'd110);
        checkOutput("box frame cy", 32'(box_cy), 32'd55);
`endif

        sendFrame(4, 20, 5, 14, 2, 2);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkOutput("small frame pulses", 32'(pulses), 32'd1);
        checkBox("small frame", 0, 5, 14, 2, 2);

        sendFrame(3, 20, 1, 0, 0, 0);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkOutput("empty frame pulses", 32'(pulses), 32'd1);
        checkBox("empty frame", 0, 0, 0, 0, 0);

        sendFrame(1, 700, 690, 690, 0, 0);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkBox("x clamp", 0, 639, 639, 0, 0);

        sendFrame(500, 2, 1, 1, 495, 499);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkBox("y clamp", 0, 1, 1, 479, 479);

        sendFrame(3, 20, 0, 19, 0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid reset mask_data", 32'(mask_data), 32'h0);
        checkOutput("mid reset box_valid", 32'(box_valid), 32'h0);
        checkBox("mid reset", 0, 0, 0, 0, 0);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkOutput("post reset first vsync pulses", 32'(pulses), 32'd0);
        sendFrame(10, 20, 2, 11, 3, 9);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkOutput("post reset second vsync pulses", 32'(pulses), 32'd1);
        checkBox("post reset frame", 1, 2, 11, 3, 9);

        cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'h60;
        tick();
        cfg_wr = 1'b0;
        checkPixel("cfg mid-frame unchanged", 8'h50, 9'h0FF);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkPixel("cfg committed cb 0x50", 8'h50, 9'h000);
        checkPixel("cfg committed cb 0x61", 8'h61, 9'h0FF);
        vsyncPulse(1'b1, 8'h30, pulses);
        checkPixel("cfg write on vsync held", 8'h50, 9'h000);
        vsyncPulse(1'b0, 8'h00, pulses);
        checkPixel("cfg write on vsync applied", 8'h50, 9'h0FF);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
